// File: rtl/prog_mem_arbiter.sv
// Program-memory arbiter: round-robin core fetches plus a host load port.
// Core fetch data returns two edges after request; host owns memory in LOAD.
module prog_mem_arbiter #(
  parameter int N  = 4,
  parameter int DW = 18,
  parameter int AW = 12
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N-1:0]    REQ,
  input  logic [N*AW-1:0] ADDR_C,
  output logic [N-1:0]    GNT,
  output logic [N-1:0]    RD_VALID,
  output logic [DW-1:0]   RD_DATA,
  input  logic            H_LOAD,
  input  logic            H_REQ,
  input  logic            H_WE,
  input  logic [AW-1:0]   H_ADDR,
  input  logic [DW-1:0]   H_DI,
  output logic            H_ACK,
  output logic            H_RVALID,
  output logic [AW-1:0]   MEM_A,
  output logic            MEM_WE,
  output logic [DW-1:0]   MEM_DI,
  input  logic [DW-1:0]   MEM_DQ
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] ptr, ptr_d;
  logic [N-1:0]  gnt_d, rdv_d;
  logic [DW-1:0] rd_data_d;
  logic          hack_d, hrv_d;
  logic [AW-1:0] a_d;
  logic          we_d;
  logic [DW-1:0] di_d;

  logic [N-1:0]  elig;
  logic          found;
  logic [PW-1:0] win;
  int            idx;

  // Cores already holding a grant are skipped, so a core never wins twice in a row.
  always_comb begin
    elig  = REQ & ~GNT;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    gnt_d     = '0;
    rdv_d     = GNT;
    hack_d    = 1'b0;
    hrv_d     = H_ACK & ~MEM_WE;
    rd_data_d = RD_DATA;
    a_d       = MEM_A;
    we_d      = 1'b0;
    di_d      = MEM_DI;

    if ((|GNT) || hrv_d)
      rd_data_d = MEM_DQ;

    unique case (state)
      RUN: begin
        if (H_LOAD) begin
          state_d = DRAIN;
        end else if (found) begin
          gnt_d[win] = 1'b1;
          a_d        = ADDR_C[int'(win)*AW +: AW];
          if (int'(win) == N - 1)
            ptr_d = '0;
          else
            ptr_d = win + 1'b1;
        end
      end
      DRAIN: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (!H_LOAD) begin
          state_d = RUN;
        end else if (H_REQ) begin
          hack_d = 1'b1;
          a_d    = H_ADDR;
          we_d   = H_WE;
          di_d   = H_DI;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RUN;
      ptr      <= '0;
      GNT      <= '0;
      RD_VALID <= '0;
      RD_DATA  <= '0;
      H_ACK    <= 1'b0;
      H_RVALID <= 1'b0;
      MEM_A    <= '0;
      MEM_WE   <= 1'b0;
      MEM_DI   <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      GNT      <= gnt_d;
      RD_VALID <= rdv_d;
      RD_DATA  <= rd_data_d;
      H_ACK    <= hack_d;
      H_RVALID <= hrv_d;
      MEM_A    <= a_d;
      MEM_WE   <= we_d;
      MEM_DI   <= di_d;
    end
  end

endmodule
